// File: rtl/vga_pattern_gen_pkg.sv
// vga_pattern_gen_pkg
//   Shared SVGA timing and colour definitions, plus the types used by the
//   pattern generator and the box mover.
//   Macros: `H_ACTIVE/`V_ACTIVE (visible area), `MODE_* (pattern select codes),
//           `COL_* (3-bit colour index: bit2=R, bit1=G, bit0=B).
//   Package: pattern enum, box direction enums, rgb_t pixel struct and
//            idx2rgb() index-to-colour expansion.

`ifndef SVGA_DEFINES
`define SVGA_DEFINES
`define H_ACTIVE   800
`define V_ACTIVE   600
`define MODE_BARS  2'd0
`define MODE_CHECK 2'd1
`define MODE_BOX   2'd2
`define MODE_GRAD  2'd3
`define COL_BLACK  3'd0
`define COL_BLUE   3'd1
`define COL_GREEN  3'd2
`define COL_CYAN   3'd3
`define COL_RED    3'd4
`define COL_MAGENT 3'd5
`define COL_YELLOW 3'd6
`define COL_WHITE  3'd7
`endif

package vga_pattern_gen_pkg;

    localparam int H_ACT = `H_ACTIVE;
    localparam int V_ACT = `V_ACTIVE;

    localparam logic [2:0] CI_BLACK = `COL_BLACK;
    localparam logic [2:0] CI_WHITE = `COL_WHITE;

    typedef enum logic [1:0] {
        PAT_BARS  = `MODE_BARS,
        PAT_CHECK = `MODE_CHECK,
        PAT_BOX   = `MODE_BOX,
        PAT_GRAD  = `MODE_GRAD
    } pat_e;

    typedef enum logic { X_RIGHT = 1'b0, X_LEFT = 1'b1 } xdir_e;
    typedef enum logic { Y_DOWN  = 1'b0, Y_UP   = 1'b1 } ydir_e;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // Each index bit drives one channel fully on or fully off.
    function automatic rgb_t idx2rgb(input logic [2:0] idx);
        rgb_t c;
        c.r = {4{idx[2]}};
        c.g = {4{idx[1]}};
        c.b = {4{idx[0]}};
        return c;
    endfunction

endpackage

// File: rtl/vga_pattern_gen_box.sv
// box_mover
//   Bouncing-box position and colour, advanced once per frame tick.
//   Two independent axis FSMs (RIGHT/LEFT on x, DOWN/UP on y) clamp the box
//   to the visible area and reverse on reaching either edge.
//   Ports: CLK, rst (sync, active high), tick (one-cycle frame strobe)
//          -> box_x, box_y (top-left corner), box_col (colour index, 1..7).

module box_mover
    import vga_pattern_gen_pkg::*;
#(
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic       tick,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic [2:0] box_col
);

    // 11-bit arithmetic so box+STEP never wraps near the far edge.
    localparam logic [10:0] X_MAX  = 11'(H_ACT - BOX_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_ACT - BOX_SIZE);
    localparam logic [10:0] STEP11 = 11'(STEP);

    xdir_e       x_state;
    ydir_e       y_state;
    logic [10:0] bx, by, x_nxt, y_nxt;
    logic        x_bnc, y_bnc;

    assign bx = {1'b0, box_x};
    assign by = {1'b0, box_y};

    always_comb begin
        x_bnc = 1'b0;
        x_nxt = bx;
        if (x_state == X_RIGHT) begin
            if (bx + STEP11 >= X_MAX) begin x_nxt = X_MAX; x_bnc = 1'b1; end
            else                             x_nxt = bx + STEP11;
        end else begin
            if (bx <= STEP11) begin x_nxt = '0; x_bnc = 1'b1; end
            else                   x_nxt = bx - STEP11;
        end
    end

    always_comb begin
        y_bnc = 1'b0;
        y_nxt = by;
        if (y_state == Y_DOWN) begin
            if (by + STEP11 >= Y_MAX) begin y_nxt = Y_MAX; y_bnc = 1'b1; end
            else                             y_nxt = by + STEP11;
        end else begin
            if (by <= STEP11) begin y_nxt = '0; y_bnc = 1'b1; end
            else                   y_nxt = by - STEP11;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            box_x   <= '0;
            box_y   <= '0;
            x_state <= X_RIGHT;
            y_state <= Y_DOWN;
            box_col <= 3'd1;
        end else if (tick) begin
            box_x <= x_nxt[9:0];
            box_y <= y_nxt[9:0];
            if (x_bnc) x_state <= (x_state == X_RIGHT) ? X_LEFT : X_RIGHT;
            if (y_bnc) y_state <= (y_state == Y_DOWN)  ? Y_UP   : Y_DOWN;
            // A corner hit counts as a single bounce; colour skips black.
            if (x_bnc || y_bnc)
                box_col <= (box_col == 3'd7) ? 3'd1 : box_col + 3'd1;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Pixel-colour stage behind the HV sync generator. Selects one of four
//   test patterns (bars, checker, bouncing box, gradient) and registers the
//   12-bit colour together with the sync pulses so they stay aligned.
//   Ports: CLK, rst (sync, active high); hPos/vPos/videoOn/HSYNC/VSYNC from
//          the timing generator; mode (pattern select, latched per frame)
//          -> R/G/B (4 bits each), HSYNC_out/VSYNC_out (1-cycle delayed).

module vga_pattern_gen
    import vga_pattern_gen_pkg::*;
#(
    parameter int BOX_SIZE = 32,
    parameter int STEP     = 2
) (
    input  logic       CLK,
    input  logic       rst,
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    input  logic       videoOn,
    input  logic       HSYNC,
    input  logic       VSYNC,
    input  logic [1:0] mode,
    output logic [3:0] R,
    output logic [3:0] G,
    output logic [3:0] B,
    output logic       HSYNC_out,
    output logic       VSYNC_out
);

    localparam logic [10:0] BSZ = 11'(BOX_SIZE);

    logic       vs_prev, tick;
    pat_e       mode_q;
    logic [7:0] frame_cnt;
    logic [9:0] box_x, box_y;
    logic [2:0] box_col;
    logic       in_box;
    rgb_t       pix;

    // Frame tick on VSYNC falling edge; vs_prev clears on reset so the
    // first cycle out of reset can never tick.
    assign tick = vs_prev & ~VSYNC;

    box_mover #(.BOX_SIZE(BOX_SIZE), .STEP(STEP)) u_box (
        .CLK     (CLK),
        .rst     (rst),
        .tick    (tick),
        .box_x   (box_x),
        .box_y   (box_y),
        .box_col (box_col)
    );

    assign in_box = ({1'b0, hPos} >= {1'b0, box_x}) && ({1'b0, hPos} < {1'b0, box_x} + BSZ) &&
                    ({1'b0, vPos} >= {1'b0, box_y}) && ({1'b0, vPos} < {1'b0, box_y} + BSZ);

    always_comb begin
        pix = '0;
        if (videoOn) begin
            unique case (mode_q)
                PAT_BARS:  pix = idx2rgb(hPos[9:7]);
                PAT_CHECK: pix = idx2rgb((hPos[5] ^ vPos[5]) ? CI_WHITE : CI_BLACK);
                PAT_BOX:   pix = idx2rgb(in_box ? box_col : CI_BLACK);
                PAT_GRAD:  begin
                    pix.r = frame_cnt[7:4];
                    pix.g = hPos[7:4];
                    pix.b = vPos[7:4];
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            vs_prev   <= 1'b0;
            mode_q    <= PAT_BARS;
            frame_cnt <= '0;
            R         <= '0;
            G         <= '0;
            B         <= '0;
            HSYNC_out <= 1'b0;
            VSYNC_out <= 1'b0;
        end else begin
            vs_prev   <= VSYNC;
            R         <= pix.r;
            G         <= pix.g;
            B         <= pix.b;
            HSYNC_out <= HSYNC;
            VSYNC_out <= VSYNC;
            // Mode only changes at frame boundaries so a frame is never mixed.
            if (tick) begin
                mode_q    <= pat_e'(mode);
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen
//   Directed bench for vga_pattern_gen. A second instance with a large box
//   makes both axes reach the top-left corner on the same frame.

module tb_vga_pattern_gen;
    import vga_pattern_gen_pkg::*;

    logic       CLK = 1'b0;
    logic       rst;
    logic [9:0] hPos, vPos;
    logic       videoOn, HSYNC, VSYNC;
    logic [1:0] mode;
    logic [3:0] R, G, B, R2, G2, B2;
    logic       HSYNC_out, VSYNC_out, hs2, vs2;
    logic [11:0] rgb;

    int n_chk  = 0;
    int n_fail = 0;

    assign rgb = {R, G, B};

    always #5 CLK = ~CLK;

    vga_pattern_gen dut (
        .CLK(CLK), .rst(rst), .hPos(hPos), .vPos(vPos), .videoOn(videoOn),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .mode(mode), .R(R), .G(G), .B(B),
        .HSYNC_out(HSYNC_out), .VSYNC_out(VSYNC_out)
    );

    // X_MAX=400, Y_MAX=200: both axes return to 0 together on frame 400.
    vga_pattern_gen #(.BOX_SIZE(400), .STEP(2)) dut2 (
        .CLK(CLK), .rst(rst), .hPos(hPos), .vPos(vPos), .videoOn(videoOn),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .mode(mode), .R(R2), .G(G2), .B(B2),
        .HSYNC_out(hs2), .VSYNC_out(vs2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    // One VSYNC pulse; returns just after the edge on which the tick acts.
    task automatic tick_frame;
        @(negedge CLK) VSYNC = 1'b1;
        @(negedge CLK) VSYNC = 1'b0;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] hpat;
        logic [15:0] vpat;
        logic        h_old, v_old;
        hpat = 16'b1100_0011_1010_0110;
        vpat = 16'b0011_1100_0000_1100;

        // ---- reset and idle ----
        rst = 1'b1; hPos = 10'd700; vPos = 10'd0; videoOn = 1'b1;
        HSYNC = 1'b1; VSYNC = 1'b0; mode = 2'd0;
        repeat (3) cyc;
        chk("rst_rgb", 32'(rgb), 32'h000);
        chk("rst_hs", 32'(HSYNC_out), 32'd0);
        chk("rst_vs", 32'(VSYNC_out), 32'd0);
        chk("rst_bx", 32'(dut.u_box.box_x), 32'd0);
        chk("rst_by", 32'(dut.u_box.box_y), 32'd0);
        chk("rst_col", 32'(dut.u_box.box_col), 32'd1);
        chk("rst_fc", 32'(dut.frame_cnt), 32'd0);
        @(negedge CLK) begin rst = 1'b0; HSYNC = 1'b0; hPos = 10'd0; end
        tick_frame;                                   // frame 1
        chk("t1_bx", 32'(dut.u_box.box_x), 32'd2);
        chk("t1_by", 32'(dut.u_box.box_y), 32'd2);
        chk("t1_fc", 32'(dut.frame_cnt), 32'd1);

        // ---- bars ----
        tick_frame;                                   // frame 2
        @(negedge CLK) begin hPos = 10'd130; vPos = 10'd10; videoOn = 1'b1; end
        #1 chk("bars_pre_edge", 32'(rgb), 32'h000);
        cyc; chk("bars_idx1", 32'(rgb), 32'h00F);
        @(negedge CLK) hPos = 10'd700;
        cyc; chk("bars_idx5", 32'(rgb), 32'hF0F);
        @(negedge CLK) videoOn = 1'b0;
        cyc; chk("bars_blank", 32'(rgb), 32'h000);

        // ---- mode latch ----
        @(negedge CLK) begin mode = 2'd1; hPos = 10'd32; vPos = 10'd0; videoOn = 1'b1; end
        cyc; chk("latch_still_bars", 32'(rgb), 32'h000);
        tick_frame;                                   // frame 3
        cyc; chk("checker_white", 32'(rgb), 32'hFFF);
        @(negedge CLK) vPos = 10'd32;
        cyc; chk("checker_black", 32'(rgb), 32'h000);

        // ---- gradient ----
        @(negedge CLK) mode = 2'd3;
        tick_frame;                                   // frame 4
        @(negedge CLK) begin hPos = 10'h05A; vPos = 10'h0C3; end
        cyc; chk("grad", 32'(rgb), 32'h05C);
        chk("grad_fc", 32'(dut.frame_cnt), 32'd4);

        // ---- box (frame 5 puts box at (10,10), colour 1 = blue) ----
        @(negedge CLK) mode = 2'd2;
        tick_frame;
        @(negedge CLK) begin hPos = 10'd10; vPos = 10'd10; end
        cyc; chk("box_tl", 32'(rgb), 32'h00F);
        @(negedge CLK) begin hPos = 10'd41; vPos = 10'd41; end
        cyc; chk("box_br", 32'(rgb), 32'h00F);
        @(negedge CLK) hPos = 10'd42;
        cyc; chk("box_right_out", 32'(rgb), 32'h000);
        @(negedge CLK) begin hPos = 10'd9; vPos = 10'd20; end
        cyc; chk("box_left_out", 32'(rgb), 32'h000);

        // ---- sync alignment across a line (bars latched again) ----
        @(negedge CLK) begin mode = 2'd0; hPos = 10'd700; end
        for (int i = 0; i < 16; i++) begin
            h_old = HSYNC; v_old = VSYNC;
            @(negedge CLK) begin HSYNC = hpat[i]; VSYNC = vpat[i]; end
            #1;
            chk("hs_hold", 32'(HSYNC_out), 32'(h_old));
            chk("vs_hold", 32'(VSYNC_out), 32'(v_old));
            cyc;
            chk("hs_dly", 32'(HSYNC_out), 32'(hpat[i]));
            chk("vs_dly", 32'(VSYNC_out), 32'(vpat[i]));
        end
        chk("pre_rst_rgb", 32'(rgb), 32'hF0F);

        // ---- reset mid-line, with a VSYNC fall while held ----
        @(negedge CLK) begin rst = 1'b1; HSYNC = 1'b1; VSYNC = 1'b1; end
        cyc;
        chk("mrst_rgb", 32'(rgb), 32'h000);
        chk("mrst_hs", 32'(HSYNC_out), 32'd0);
        chk("mrst_vs", 32'(VSYNC_out), 32'd0);
        chk("mrst_fc", 32'(dut.frame_cnt), 32'd0);
        chk("mrst_mode", 32'(dut.mode_q), 32'd0);
        @(negedge CLK) VSYNC = 1'b0;
        cyc;
        chk("mrst_tick_ignored_fc", 32'(dut.frame_cnt), 32'd0);
        chk("mrst_bx", 32'(dut.u_box.box_x), 32'd0);
        chk("mrst_col", 32'(dut.u_box.box_col), 32'd1);

        // ---- long run from reset: bounces, corner, colour wrap ----
        @(negedge CLK) begin rst = 1'b0; HSYNC = 1'b0; end
        for (int t = 1; t <= 700; t++) begin
            tick_frame;
            if (t == 284) begin
                chk("y_bounce_by", 32'(dut.u_box.box_y), 32'd568);
                chk("y_bounce_st", 32'(dut.u_box.y_state), 32'(Y_UP));
                chk("y_bounce_col", 32'(dut.u_box.box_col), 32'd2);
            end
            if (t == 383) begin
                chk("x_pre_bx", 32'(dut.u_box.box_x), 32'd766);
                chk("x_pre_col", 32'(dut.u_box.box_col), 32'd2);
            end
            if (t == 384) begin
                chk("x_bounce_bx", 32'(dut.u_box.box_x), 32'd768);
                chk("x_bounce_st", 32'(dut.u_box.x_state), 32'(X_LEFT));
                chk("x_bounce_col", 32'(dut.u_box.box_col), 32'd3);
            end
            if (t == 385)
                chk("x_back_bx", 32'(dut.u_box.box_x), 32'd766);
            if (t == 399) begin
                chk("c_pre_bx", 32'(dut2.u_box.box_x), 32'd2);
                chk("c_pre_by", 32'(dut2.u_box.box_y), 32'd2);
                chk("c_pre_xs", 32'(dut2.u_box.x_state), 32'(X_LEFT));
                chk("c_pre_ys", 32'(dut2.u_box.y_state), 32'(Y_UP));
                chk("c_pre_col", 32'(dut2.u_box.box_col), 32'd4);
            end
            if (t == 400) begin
                chk("c_bx", 32'(dut2.u_box.box_x), 32'd0);
                chk("c_by", 32'(dut2.u_box.box_y), 32'd0);
                chk("c_xs", 32'(dut2.u_box.x_state), 32'(X_RIGHT));
                chk("c_ys", 32'(dut2.u_box.y_state), 32'(Y_DOWN));
                chk("c_col", 32'(dut2.u_box.box_col), 32'd5);
            end
            if (t == 600)
                chk("col7", 32'(dut2.u_box.box_col), 32'd7);
            if (t == 700) begin
                chk("col_wrap", 32'(dut2.u_box.box_col), 32'd1);
                chk("fc_wrap", 32'(dut.frame_cnt), 32'd188);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
